// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the mem_req_ctrl dual-port SRAM request front-end.
// Optional alignment checking is enabled by defining MEM_REQ_CTRL_ALIGN_CHECK_EN.
package mem_ctrl_pkg;

  localparam int unsigned MEM_DATA_W         = 32;
  localparam int unsigned MEM_ADDR_W         = 32;
  localparam int unsigned PROT_LIMIT_DEFAULT = 1000;

  typedef logic [MEM_ADDR_W-1:0] addr_t;
  typedef logic [MEM_DATA_W-1:0] data_t;

  typedef struct packed {
    logic  we;
    addr_t addr;
    data_t wdata;
  } mem_req_t;

  typedef struct packed {
    data_t rdata;
    logic  err;
  } mem_rsp_t;

  // True when the 4-byte windows starting at a and b share a byte (wrapping distance < 4).
  function automatic logic overlap4(input addr_t a, input addr_t b);
    addr_t d_ab;
    addr_t d_ba;
    d_ab = a - b;
    d_ba = b - a;
    return (d_ab < addr_t'(4)) || (d_ba < addr_t'(4));
  endfunction

endpackage

// File: rtl/mem_port_pipe.sv
// One requester port: ISSUE and RESP stages, error check and the SRAM port drive.
// MEM_REQ_CTRL_ALIGN_CHECK_EN turns unaligned requests into error responses.
module mem_port_pipe
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned PROT_LIMIT = PROT_LIMIT_DEFAULT
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     i_req_valid,
  output logic     o_req_ready,
  input  mem_req_t i_req,
  input  logic     i_rsp_ready,
  output logic     o_rsp_valid,
  output mem_rsp_t o_rsp,
  input  logic     i_stall,
  input  data_t    i_sram_q,
  output addr_t    o_sram_addr,
  output data_t    o_sram_data,
  output logic     o_sram_we,
  output logic     o_hz_valid,
  output logic     o_hz_we,
  output addr_t    o_hz_addr
);

  logic     r_issue_v;
  logic     r_issue_err;
  mem_req_t r_issue;
  logic     r_resp_v;
  logic     r_resp_err;
  logic     r_resp_fresh;
  data_t    r_resp_hold;
  addr_t    r_sram_addr;
  data_t    r_sram_data;

  logic w_align_err;
  logic w_req_err;
  logic w_resp_free;
  logic w_issue_adv;
  logic w_accept;
  logic w_drive;

`ifdef MEM_REQ_CTRL_ALIGN_CHECK_EN
  assign w_align_err = (i_req.addr[1:0] != 2'b00);
`else
  assign w_align_err = 1'b0;
`endif

  assign w_req_err   = (i_req.we && (i_req.addr < addr_t'(PROT_LIMIT))) || w_align_err;
  assign w_resp_free = !r_resp_v || i_rsp_ready;
  assign w_issue_adv = r_issue_v && !i_stall && w_resp_free;
  assign o_req_ready = !r_issue_v || w_issue_adv;
  assign w_accept    = i_req_valid && o_req_ready;

  // Error requests never touch the SRAM; the port then holds its last address/data.
  assign w_drive     = r_issue_v && !r_issue_err && !i_stall;
  assign o_sram_we   = w_drive && r_issue.we;
  assign o_sram_addr = w_drive ? r_issue.addr  : r_sram_addr;
  assign o_sram_data = w_drive ? r_issue.wdata : r_sram_data;

  // The SRAM word is visible only in the cycle after capture, so it is parked in
  // r_resp_hold on the next edge to stay stable under backpressure.
  assign o_rsp_valid = r_resp_v;
  assign o_rsp       = '{rdata: (r_resp_fresh ? i_sram_q : r_resp_hold), err: r_resp_err};

  assign o_hz_valid  = r_issue_v && !r_issue_err;
  assign o_hz_we     = r_issue.we;
  assign o_hz_addr   = r_issue.addr;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order within or across blocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_issue_v    <= 1'b0;
      r_issue_err  <= 1'b0;
      r_issue      <= '0;
      r_resp_v     <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_fresh <= 1'b0;
      r_resp_hold  <= '0;
      r_sram_addr  <= '0;
      r_sram_data  <= '0;
    end else begin
      r_sram_addr <= o_sram_addr;
      r_sram_data <= o_sram_data;

      if (w_accept) begin
        r_issue_v   <= 1'b1;
        r_issue     <= i_req;
        r_issue_err <= w_req_err;
      end else if (w_issue_adv) begin
        r_issue_v <= 1'b0;
      end

      if (w_issue_adv) begin
        r_resp_v     <= 1'b1;
        r_resp_err   <= r_issue_err;
        r_resp_fresh <= !r_issue_err;
        r_resp_hold  <= '0;
      end else begin
        if (i_rsp_ready) r_resp_v <= 1'b0;
        if (r_resp_fresh) begin
          r_resp_hold  <= i_sram_q;
          r_resp_fresh <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// Dual-port request front-end for the byte-addressable SRAM; port A has priority.
// Define MEM_REQ_CTRL_ALIGN_CHECK_EN to reject requests with addr[1:0] != 0.
module mem_req_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MEM_DATA_W,
  parameter int unsigned ADDR_WIDTH = MEM_ADDR_W,
  parameter int unsigned PROT_LIMIT = PROT_LIMIT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req_valid,
  output logic                  a_req_ready,
  input  logic                  a_req_we,
  input  logic [ADDR_WIDTH-1:0] a_req_addr,
  input  logic [DATA_WIDTH-1:0] a_req_wdata,
  output logic                  a_rsp_valid,
  input  logic                  a_rsp_ready,
  output logic [DATA_WIDTH-1:0] a_rsp_rdata,
  output logic                  a_rsp_err,
  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  input  logic                  b_req_we,
  input  logic [ADDR_WIDTH-1:0] b_req_addr,
  input  logic [DATA_WIDTH-1:0] b_req_wdata,
  output logic                  b_rsp_valid,
  input  logic                  b_rsp_ready,
  output logic [DATA_WIDTH-1:0] b_rsp_rdata,
  output logic                  b_rsp_err,
  output logic [ADDR_WIDTH-1:0] sram_addr_a,
  output logic [ADDR_WIDTH-1:0] sram_addr_b,
  output logic [DATA_WIDTH-1:0] sram_data_a,
  output logic [DATA_WIDTH-1:0] sram_data_b,
  output logic                  sram_we_a,
  output logic                  sram_we_b,
  input  logic [DATA_WIDTH-1:0] sram_q_a,
  input  logic [DATA_WIDTH-1:0] sram_q_b
);

  mem_req_t w_a_req, w_b_req;
  mem_rsp_t w_a_rsp, w_b_rsp;
  logic     w_a_hz_v, w_a_hz_we, w_b_hz_v, w_b_hz_we;
  addr_t    w_a_hz_addr, w_b_hz_addr;
  logic     w_stall_b;

  assign w_a_req = '{we: a_req_we, addr: a_req_addr, wdata: a_req_wdata};
  assign w_b_req = '{we: b_req_we, addr: b_req_addr, wdata: b_req_wdata};

  // B waits while its window overlaps A's live ISSUE and either side writes,
  // so it issues after A's access and observes A's write.
  assign w_stall_b = w_a_hz_v && w_b_hz_v && (w_a_hz_we || w_b_hz_we) &&
                     overlap4(w_a_hz_addr, w_b_hz_addr);

  mem_port_pipe #(.PROT_LIMIT(PROT_LIMIT)) u_port_a (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (a_req_valid),
    .o_req_ready (a_req_ready),
    .i_req       (w_a_req),
    .i_rsp_ready (a_rsp_ready),
    .o_rsp_valid (a_rsp_valid),
    .o_rsp       (w_a_rsp),
    .i_stall     (1'b0),
    .i_sram_q    (sram_q_a),
    .o_sram_addr (sram_addr_a),
    .o_sram_data (sram_data_a),
    .o_sram_we   (sram_we_a),
    .o_hz_valid  (w_a_hz_v),
    .o_hz_we     (w_a_hz_we),
    .o_hz_addr   (w_a_hz_addr)
  );

  mem_port_pipe #(.PROT_LIMIT(PROT_LIMIT)) u_port_b (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (b_req_valid),
    .o_req_ready (b_req_ready),
    .i_req       (w_b_req),
    .i_rsp_ready (b_rsp_ready),
    .o_rsp_valid (b_rsp_valid),
    .o_rsp       (w_b_rsp),
    .i_stall     (w_stall_b),
    .i_sram_q    (sram_q_b),
    .o_sram_addr (sram_addr_b),
    .o_sram_data (sram_data_b),
    .o_sram_we   (sram_we_b),
    .o_hz_valid  (w_b_hz_v),
    .o_hz_we     (w_b_hz_we),
    .o_hz_addr   (w_b_hz_addr)
  );

  assign a_rsp_rdata = w_a_rsp.rdata;
  assign a_rsp_err   = w_a_rsp.err;
  assign b_rsp_rdata = w_b_rsp.rdata;
  assign b_rsp_err   = w_b_rsp.err;

endmodule
